// File: rtl/dpb_pkg.sv
// -----------------------------------------------------------------------------
// dpb_pkg
// Shared definitions for the dual-port block RAM bus responders.
//   - Geometry: 4096 x 32 words, 4 byte strobes.
//   - FSM state encoding for dpb_bus_port (kept as plain constants so the
//     encoding is fixed and easy to probe from checkers).
//   - Small helpers for classifying byte strobes.
// -----------------------------------------------------------------------------
package dpb_pkg;

    localparam int DPB_DATA_W = 32;
    localparam int DPB_STRB_W = 4;
    localparam int DPB_ADDR_W = 12;

    typedef logic [2:0] dpb_state_t;

    localparam dpb_state_t IDLE   = 3'd0;
    localparam dpb_state_t ISSUE  = 3'd1;
    localparam dpb_state_t RD_CAP = 3'd2;
    localparam dpb_state_t RMW_RD = 3'd3;
    localparam dpb_state_t RESP   = 3'd4;

    // All bytes written: the RAM can take the word directly.
    function automatic logic strb_full(input logic [DPB_STRB_W-1:0] s);
        return s == {DPB_STRB_W{1'b1}};
    endfunction

    // No bytes written: nothing to do in the RAM at all.
    function automatic logic strb_empty(input logic [DPB_STRB_W-1:0] s);
        return s == '0;
    endfunction

endpackage

// File: rtl/dpb_byte_merge.sv
// -----------------------------------------------------------------------------
// dpb_byte_merge
// Combinational per-byte merge used to turn a strobed write into a full-word
// write: each byte comes from wdata when its strobe is set, else from the
// old word read out of the RAM.
// Ports:
//   wdata    in  32  new write data
//   old_data in  32  current RAM contents of the target word
//   wstrb    in  4   byte strobes, bit i selects bits [8i+7:8i]
//   merged   out 32  word to write back
// -----------------------------------------------------------------------------
module dpb_byte_merge
    import dpb_pkg::*;
(
    input  logic [DPB_DATA_W-1:0] wdata,
    input  logic [DPB_DATA_W-1:0] old_data,
    input  logic [DPB_STRB_W-1:0] wstrb,
    output logic [DPB_DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < DPB_STRB_W; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dpb_bus_port.sv
// -----------------------------------------------------------------------------
// dpb_bus_port
// Bus-side responder owning one port of the 4096x32 dual-port block RAM.
// Accepts one byte-addressed request at a time, performs it on the RAM
// (partial writes as read-modify-write, since the RAM has no byte enables)
// and returns a response that is held until consumed.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid & ready are both 1. The request master holds req_* stable while
// req_valid is high and not yet accepted; resp_valid/resp_rdata stay stable
// until the edge where resp_ready is also high.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr            1=write; byte address (bits [1:0] ignored)
//   req_wdata, req_wstrb        write data and byte strobes
//   resp_valid/resp_ready       response handshake
//   resp_rdata                  read data, 0 for write acks
//   bram_ce/oce/wre/ad/din      RAM port command pins (oce tied 1)
//   bram_dout                   RAM read data, valid 1 cycle after a read edge
// -----------------------------------------------------------------------------
module dpb_bus_port
    import dpb_pkg::*;
#(
    parameter int ADDR_W = DPB_ADDR_W,
    parameter int DATA_W = DPB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DPB_STRB_W-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                bram_ce,
    output logic                bram_oce,
    output logic                bram_wre,
    output logic [ADDR_W-1:0]   bram_ad,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);

    dpb_state_t             state;
    logic                   ready_en;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DPB_STRB_W-1:0]  wstrb_q;
    logic                   we_q;
    logic [DATA_W-1:0]      merged;

    // Byte-offset bits carry no meaning for a word-wide RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];

    // ready_en keeps req_ready low for the first cycle after reset release.
    assign req_ready = ready_en & (state == IDLE);

    dpb_byte_merge u_merge (
        .wdata    (wdata_q),
        .old_data (bram_dout),
        .wstrb    (wstrb_q),
        .merged   (merged)
    );

    // RAM commands come only from registered request fields. The ce/wre
    // strobes are additionally gated by rst_n so an asynchronous reset in the
    // middle of a read-modify-write can never commit a half-merged word.
    always_comb begin
        bram_ce  = 1'b0;
        bram_wre = 1'b0;
        if (state == ISSUE) begin
            if (!we_q) begin
                bram_ce = 1'b1;
            end else if (strb_full(wstrb_q)) begin
                bram_ce  = 1'b1;
                bram_wre = 1'b1;
            end else if (!strb_empty(wstrb_q)) begin
                bram_ce = 1'b1;  // read half of the RMW
            end
        end else if (state == RMW_RD) begin
            bram_ce  = 1'b1;
            bram_wre = 1'b1;
        end
        bram_ce  = bram_ce  & rst_n;
        bram_wre = bram_wre & rst_n;
    end

    assign bram_oce = 1'b1;
    assign bram_ad  = addr_q;
    // Old data only exists during RMW_RD, so the merge stays combinational
    // there; otherwise the latched write data goes straight out.
    assign bram_din = (state == RMW_RD) ? merged : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        we_q    <= req_we;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!we_q) begin
                        state <= RD_CAP;
                    end else if (strb_full(wstrb_q) || strb_empty(wstrb_q)) begin
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= RMW_RD;
                    end
                end
                RD_CAP: begin
                    resp_rdata <= bram_dout;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
